id_funct_bundle: RTL and testbench
==================================

# id_funct_bundle

Parametrised, registered successor of the ID-stage funct generator. Decodes a bundle of up to ISSUE_WIDTH MIPS instructions per cycle into the `FUNCT_*` operation codes consumed by the function units. Holds the results in a 2-entry skid buffer with valid/ready handshakes on both sides. Sits between the fetch/decode bundle register and rename/dispatch, and supports pipeline flush.

## Interface
- ISSUE_WIDTH, 2, number of lanes per bundle (1..4)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all buffered bundles and the current input
- in_valid  in  1  input bundle present
- in_ready  out  1  block can accept a bundle this cycle
- in_lane_mask  in  ISSUE_WIDTH  per-lane instruction valid
- in_op  in  6*ISSUE_WIDTH  lane i opcode at [6i+5:6i]
- in_funct  in  6*ISSUE_WIDTH  lane i funct field
- in_rt  in  5*ISSUE_WIDTH  lane i rt field
- out_valid  out  1  head bundle valid
- out_ready  in  1  consumer accepts head bundle
- out_lane_mask  out  ISSUE_WIDTH  lane mask of the head bundle
- out_funct  out  `FUNCT_BUS` width*ISSUE_WIDTH  decoded funct per lane
- out_illegal  out  ISSUE_WIDTH  lane holds an undecodable SPECIAL2 instruction

## Operation
- Per-lane decode is combinational on the input bundle:
  - SPECIAL: funct passes through.
  - SPECIAL2: MADD/MADDU/MUL/MSUB/MSUBU/CLZ/CLO map to the matching `FUNCT2_*` code. Any other funct gives `FUNCT_NOP` with illegal=1.
  - ORI/LUI/JAL give `FUNCT_OR`. ANDI gives `FUNCT_AND`. XORI gives `FUNCT_XOR`.
  - LB/LBU/LH/LHU/LW/SB/SH/SW/ADDI give `FUNCT_ADD`. ADDIU gives `FUNCT_ADDU`.
  - SLTI gives `FUNCT_SLT`. SLTIU gives `FUNCT_SLTU`.
  - REGIMM with rt=BLTZAL/BGEZAL gives `FUNCT_OR`.
  - Everything else gives `FUNCT_NOP` with illegal=0.
- A lane with in_lane_mask[i]=0 decodes to `FUNCT_NOP` with illegal=0, regardless of its fields.
- Decoded bundle (funct, illegal, mask) is written into the buffer. Output ports always show the head entry.
- Buffer state machine, count 0..2:
  - EMPTY (count 0): in_ready=1, out_valid=0.
  - ONE (count 1): in_ready=1, out_valid=1.
  - FULL (count 2): in_ready=0, out_valid=1.
- Write occurs when in_valid & in_ready. Read occurs when out_valid & out_ready.
- Transitions (no flush):
  - EMPTY, write: go to ONE.
  - ONE, write without read: go to FULL.
  - ONE, read without write: go to EMPTY.
  - ONE, write and read together: stay in ONE; the new bundle becomes head.
  - FULL, read: go to ONE; the second entry becomes head.
  - FULL: a write cannot occur because in_ready=0.
- Buffer order is FIFO. A bundle is never reordered, duplicated or dropped, except by flush.
- Flush has priority over everything:
  - Next state is EMPTY.
  - The input bundle in the flush cycle is not written, even if in_valid & in_ready.
  - A read in the flush cycle still counts as consumed by the consumer.
- in_ready is a registered function of state only. It never depends combinationally on out_ready.

## Timing
- Latency is 1 cycle: a bundle accepted on edge N is visible on out_* after edge N, provided the buffer was EMPTY or head was read on the same edge.
- Throughput is 1 bundle/cycle while out_ready=1.
- Reset (rst=0), applied asynchronously:
  - State goes to EMPTY.
  - out_valid=0, in_ready=1.
  - out_funct = `FUNCT_NOP` on all lanes.
  - out_lane_mask=0, out_illegal=0.
- Reset mid-transfer discards all buffered bundles.
- out_funct, out_lane_mask and out_illegal are held stable while out_valid=1 and out_ready=0.

## Configuration
- FUNCT_SPECIAL2_EN
  - Defined: SPECIAL2 decodes as described in Operation.
  - Undefined: every SPECIAL2 lane with mask=1 yields `FUNCT_NOP` with out_illegal=1. The SPECIAL2 decode logic is not synthesised.

## Test plan
- Reset then single bundle, ISSUE_WIDTH=2:
  - Stimulus: lane0 op=0x0D (ORI), lane1 op=0x09 (ADDIU), mask=2'b11, out_ready=1.
  - Required: next cycle out_valid=1, out_funct = {`FUNCT_ADDU`, `FUNCT_OR`}, out_illegal=0.
- Backpressure:
  - Stimulus: out_ready=0, 3 consecutive bundles offered.
  - Required: first two accepted. in_ready=0 after the second. Third is held until one read. Drain order is 1,2,3.
- SPECIAL2:
  - Stimulus: op=0x1C with funct 0x02 (MUL), then funct 0x3F.
  - Required: first gives `FUNCT2_MUL`, illegal=0. Second gives `FUNCT_NOP`, illegal=1.
  - With FUNCT_SPECIAL2_EN undefined, both give `FUNCT_NOP` with illegal=1.
- Masked lane and REGIMM:
  - Stimulus: lane0 op=0x01 rt=0x11 (BGEZAL), lane1 op=0x00 funct=0x25 with mask bit 0.
  - Required: `FUNCT_OR`, `FUNCT_NOP`.
- Flush:
  - Stimulus: FULL state, flush=1 together with in_valid=1.
  - Required: next cycle out_valid=0 and in_ready=1. The flushed input never appears on the output.
- Async reset mid-stream:
  - Stimulus: drop rst between clock edges while in ONE.
  - Required: out_valid=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/id_funct_bundle_if.sv
// Handshake bundle between the fetch/decode register, the funct decoder and dispatch.
// The slave modport is the decoder's view of the bus.
interface id_funct_bundle_if #(
    parameter int IW = 2,
    parameter int FW = 7
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   in_lane_mask;
    logic [6*IW-1:0] in_op;
    logic [6*IW-1:0] in_funct;
    logic [5*IW-1:0] in_rt;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_lane_mask;
    logic [FW*IW-1:0] out_funct;
    logic [IW-1:0]   out_illegal;

    modport slave (
        input  flush, in_valid, in_lane_mask, in_op, in_funct, in_rt,
        input  out_ready,
        output in_ready, out_valid, out_lane_mask, out_funct, out_illegal
    );

    modport master (
        output flush, in_valid, in_lane_mask, in_op, in_funct, in_rt,
        output out_ready,
        input  in_ready, out_valid, out_lane_mask, out_funct, out_illegal
    );
endinterface

// File: rtl/id_funct_bundle.sv
// Registered multi-lane MIPS funct decoder feeding a 2-entry skid buffer.
// Define FUNCT_SPECIAL2_EN to decode SPECIAL2; otherwise SPECIAL2 lanes flag illegal.
module id_funct_bundle #(
    parameter int ISSUE_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    id_funct_bundle_if.slave   bus
);
    localparam int IW = ISSUE_WIDTH;
    localparam int FW = 7;

    // Bit 6 separates SPECIAL2 codes from the SPECIAL funct space.
    localparam logic [FW-1:0] FUNCT_NOP    = 7'h00;
    localparam logic [FW-1:0] FUNCT_ADD    = 7'h20;
    localparam logic [FW-1:0] FUNCT_ADDU   = 7'h21;
    localparam logic [FW-1:0] FUNCT_AND    = 7'h24;
    localparam logic [FW-1:0] FUNCT_OR     = 7'h25;
    localparam logic [FW-1:0] FUNCT_XOR    = 7'h26;
    localparam logic [FW-1:0] FUNCT_SLT    = 7'h2A;
    localparam logic [FW-1:0] FUNCT_SLTU   = 7'h2B;
`ifdef FUNCT_SPECIAL2_EN
    localparam logic [FW-1:0] FUNCT2_MADD  = 7'h40;
    localparam logic [FW-1:0] FUNCT2_MADDU = 7'h41;
    localparam logic [FW-1:0] FUNCT2_MUL   = 7'h42;
    localparam logic [FW-1:0] FUNCT2_MSUB  = 7'h44;
    localparam logic [FW-1:0] FUNCT2_MSUBU = 7'h45;
    localparam logic [FW-1:0] FUNCT2_CLZ   = 7'h60;
    localparam logic [FW-1:0] FUNCT2_CLO   = 7'h61;
`endif

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [IW-1:0]    mask;
        logic [IW-1:0]    ill;
        logic [FW*IW-1:0] funct;
    } entry_t;

    state_t state, state_n;
    entry_t e0, e1, e0_n, e1_n, dec;
    logic   in_rdy, out_vld, wr, rd;

    function automatic logic [FW:0] dec_lane(
        input logic [5:0] op,
        input logic [5:0] fn,
        input logic [4:0] rt
    );
        logic [FW:0] r;
        r = {1'b0, FUNCT_NOP};
        unique case (op)
            6'h00: r = {2'b00, fn};
            6'h01: if (rt == 5'h10 || rt == 5'h11) r = {1'b0, FUNCT_OR};
            6'h03, 6'h0D, 6'h0F: r = {1'b0, FUNCT_OR};
            6'h0C: r = {1'b0, FUNCT_AND};
            6'h0E: r = {1'b0, FUNCT_XOR};
            6'h08, 6'h20, 6'h21, 6'h23, 6'h24,
            6'h25, 6'h28, 6'h29, 6'h2B: r = {1'b0, FUNCT_ADD};
            6'h09: r = {1'b0, FUNCT_ADDU};
            6'h0A: r = {1'b0, FUNCT_SLT};
            6'h0B: r = {1'b0, FUNCT_SLTU};
            6'h1C: begin
`ifdef FUNCT_SPECIAL2_EN
                unique case (fn)
                    6'h00:   r = {1'b0, FUNCT2_MADD};
                    6'h01:   r = {1'b0, FUNCT2_MADDU};
                    6'h02:   r = {1'b0, FUNCT2_MUL};
                    6'h04:   r = {1'b0, FUNCT2_MSUB};
                    6'h05:   r = {1'b0, FUNCT2_MSUBU};
                    6'h20:   r = {1'b0, FUNCT2_CLZ};
                    6'h21:   r = {1'b0, FUNCT2_CLO};
                    default: r = {1'b1, FUNCT_NOP};
                endcase
`else
                r = {1'b1, FUNCT_NOP};
`endif
            end
            default: r = {1'b0, FUNCT_NOP};
        endcase
        return r;
    endfunction

    always_comb begin
        dec      = '0;
        dec.mask = bus.in_lane_mask;
        for (int i = 0; i < IW; i++) begin
            if (bus.in_lane_mask[i]) begin
                {dec.ill[i], dec.funct[FW*i +: FW]} =
                    dec_lane(bus.in_op[6*i +: 6],
                             bus.in_funct[6*i +: 6],
                             bus.in_rt[5*i +: 5]);
            end
        end
    end

    assign in_rdy  = (state != FULL);
    assign out_vld = (state != EMPTY);
    assign wr      = bus.in_valid & in_rdy;
    assign rd      = out_vld & bus.out_ready;

    always_comb begin
        state_n = state;
        e0_n    = e0;
        e1_n    = e1;
        if (bus.flush) begin
            state_n = EMPTY;
            e0_n    = '0;
        end else begin
            unique case (state)
                EMPTY: if (wr) begin
                    state_n = ONE;
                    e0_n    = dec;
                end
                ONE: begin
                    if (wr && rd) begin
                        e0_n = dec;
                    end else if (wr) begin
                        state_n = FULL;
                        e1_n    = dec;
                    end else if (rd) begin
                        state_n = EMPTY;
                    end
                end
                FULL: if (rd) begin
                    state_n = ONE;
                    e0_n    = e1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            state <= state_n;
            e0    <= e0_n;
            e1    <= e1_n;
        end
    end

    assign bus.in_ready      = in_rdy;
    assign bus.out_valid     = out_vld;
    assign bus.out_lane_mask = e0.mask;
    assign bus.out_illegal   = e0.ill;
    assign bus.out_funct     = e0.funct;
endmodule

// File: tb/tb_id_funct_bundle.sv
// Bench for id_funct_bundle: decode vector table, handshake corner cases,
// and a randomized run against a queue-based reference.
module tb_id_funct_bundle;
    localparam int IW = 2;
    localparam int FW = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_funct_bundle_if #(.IW(IW), .FW(FW)) bus ();

    id_funct_bundle #(.ISSUE_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [1:0]  ill;
        logic [13:0] f;
    } exp_t;

    logic [6:0] omap [64];

    function automatic void ref_lane(input logic m, input logic [5:0] op,
                                     input logic [5:0] fn, input logic [4:0] rt,
                                     output logic [6:0] f, output logic il);
        f  = 7'h00;
        il = 1'b0;
        if (m) begin
            if (op == 6'h00) begin
                f = {1'b0, fn};
            end else if (op == 6'h01) begin
                if (rt == 5'h10 || rt == 5'h11) f = 7'h25;
            end else if (op == 6'h1C) begin
`ifdef FUNCT_SPECIAL2_EN
                if (fn inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h20, 6'h21})
                    f = {1'b1, fn};
                else
                    il = 1'b1;
`else
                il = 1'b1;
`endif
            end else begin
                f = omap[op];
            end
        end
    endfunction

    function automatic exp_t ref_bundle(input logic [1:0] m, input logic [11:0] op,
                                        input logic [11:0] fn, input logic [9:0] rt);
        exp_t e;
        logic [6:0] f;
        logic il;
        e.mask = m;
        e.ill  = '0;
        e.f    = '0;
        for (int i = 0; i < IW; i++) begin
            ref_lane(m[i], op[6*i +: 6], fn[6*i +: 6], rt[5*i +: 5], f, il);
            e.f[7*i +: 7] = f;
            e.ill[i]      = il;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] m,
                         input logic [5:0] op0, input logic [5:0] fn0, input logic [4:0] rt0,
                         input logic [5:0] op1, input logic [5:0] fn1, input logic [4:0] rt1);
        bus.in_valid     = v;
        bus.in_lane_mask = m;
        bus.in_op        = {op1, op0};
        bus.in_funct     = {fn1, fn0};
        bus.in_rt        = {rt1, rt0};
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [5:0]  op0, fn0;
        logic [4:0]  rt0;
        logic [5:0]  op1, fn1;
        logic [4:0]  rt1;
        logic [13:0] ef;
        logic [1:0]  eil;
    } vec_t;

    vec_t tv [12];

    logic [5:0] ops [23] = '{6'h00, 6'h01, 6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h1C, 6'h1C, 6'h20,
                             6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h04, 6'h3F};

    initial begin
        exp_t q [$];
        exp_t e;
        logic acc, rdm;
        logic [11:0] rop, rfn;
        logic [9:0]  rrt;

        foreach (omap[i]) omap[i] = 7'h00;
        omap[6'h03] = 7'h25; omap[6'h0D] = 7'h25; omap[6'h0F] = 7'h25;
        omap[6'h0C] = 7'h24; omap[6'h0E] = 7'h26;
        omap[6'h09] = 7'h21; omap[6'h0A] = 7'h2A; omap[6'h0B] = 7'h2B;
        foreach (ops[i]) if (ops[i] inside {6'h08, 6'h20, 6'h21, 6'h23, 6'h24,
                                            6'h25, 6'h28, 6'h29, 6'h2B})
            omap[ops[i]] = 7'h20;

        tv[0]  = '{2'b11, 6'h0D, 6'h00, 5'h00, 6'h09, 6'h00, 5'h00, {7'h21, 7'h25}, 2'b00};
`ifdef FUNCT_SPECIAL2_EN
        tv[1]  = '{2'b11, 6'h1C, 6'h02, 5'h00, 6'h1C, 6'h3F, 5'h00, {7'h00, 7'h42}, 2'b10};
        tv[9]  = '{2'b11, 6'h1C, 6'h20, 5'h00, 6'h1C, 6'h05, 5'h00, {7'h45, 7'h60}, 2'b00};
`else
        tv[1]  = '{2'b11, 6'h1C, 6'h02, 5'h00, 6'h1C, 6'h3F, 5'h00, {7'h00, 7'h00}, 2'b11};
        tv[9]  = '{2'b11, 6'h1C, 6'h20, 5'h00, 6'h1C, 6'h05, 5'h00, {7'h00, 7'h00}, 2'b11};
`endif
        tv[2]  = '{2'b01, 6'h01, 6'h00, 5'h11, 6'h00, 6'h25, 5'h00, {7'h00, 7'h25}, 2'b00};
        tv[3]  = '{2'b11, 6'h23, 6'h00, 5'h00, 6'h0B, 6'h00, 5'h00, {7'h2B, 7'h20}, 2'b00};
        tv[4]  = '{2'b11, 6'h0C, 6'h00, 5'h00, 6'h0E, 6'h00, 5'h00, {7'h26, 7'h24}, 2'b00};
        tv[5]  = '{2'b11, 6'h0F, 6'h00, 5'h00, 6'h03, 6'h00, 5'h00, {7'h25, 7'h25}, 2'b00};
        tv[6]  = '{2'b11, 6'h0A, 6'h00, 5'h00, 6'h01, 6'h00, 5'h00, {7'h00, 7'h2A}, 2'b00};
        tv[7]  = '{2'b11, 6'h00, 6'h2A, 5'h00, 6'h2B, 6'h00, 5'h00, {7'h20, 7'h2A}, 2'b00};
        tv[8]  = '{2'b10, 6'h1C, 6'h3F, 5'h00, 6'h04, 6'h00, 5'h00, {7'h00, 7'h00}, 2'b00};
        tv[10] = '{2'b11, 6'h24, 6'h00, 5'h00, 6'h01, 6'h00, 5'h10, {7'h25, 7'h20}, 2'b00};
        tv[11] = '{2'b11, 6'h28, 6'h00, 5'h00, 6'h08, 6'h00, 5'h00, {7'h20, 7'h20}, 2'b00};

        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 2'b00, 6'h0, 6'h0, 5'h0, 6'h0, 6'h0, 5'h0);

        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_funct", bus.out_funct, 14'h0);
        chk("rst_mask", bus.out_lane_mask, 2'b00);
        chk("rst_ill", bus.out_illegal, 2'b00);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive(1'b1, tv[i].mask, tv[i].op0, tv[i].fn0, tv[i].rt0,
                  tv[i].op1, tv[i].fn1, tv[i].rt1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
            chk($sformatf("vec%0d_funct", i), bus.out_funct, tv[i].ef);
            chk($sformatf("vec%0d_ill", i), bus.out_illegal, tv[i].eil);
            chk($sformatf("vec%0d_mask", i), bus.out_lane_mask, tv[i].mask);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_empty", bus.out_valid, 1'b0);

        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b11, 6'h0D, 6'h0, 5'h0, 6'h0D, 6'h0, 5'h0);
        @(posedge clk);
        #1;
        chk("bp_ready1", bus.in_ready, 1'b1);
        chk("bp_head1", bus.out_funct, {7'h25, 7'h25});
        @(negedge clk);
        drive(1'b1, 2'b11, 6'h0C, 6'h0, 5'h0, 6'h0C, 6'h0, 5'h0);
        @(posedge clk);
        #1;
        chk("bp_ready2", bus.in_ready, 1'b0);
        chk("bp_head2", bus.out_funct, {7'h25, 7'h25});
        @(negedge clk);
        drive(1'b1, 2'b11, 6'h0E, 6'h0, 5'h0, 6'h0E, 6'h0, 5'h0);
        @(posedge clk);
        #1;
        chk("bp_ready3", bus.in_ready, 1'b0);
        chk("bp_hold", bus.out_funct, {7'h25, 7'h25});
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_second", bus.out_funct, {7'h24, 7'h24});
        chk("bp_ready4", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_third", bus.out_funct, {7'h26, 7'h26});
        chk("bp_valid3", bus.out_valid, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_empty", bus.out_valid, 1'b0);

        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b11, 6'h0D, 6'h0, 5'h0, 6'h0D, 6'h0, 5'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2'b11, 6'h0C, 6'h0, 5'h0, 6'h0C, 6'h0, 5'h0);
        @(posedge clk);
        #1;
        chk("fl_full", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush = 1'b1;
        drive(1'b1, 2'b11, 6'h23, 6'h0, 5'h0, 6'h23, 6'h0, 5'h0);
        @(posedge clk);
        #1;
        chk("fl_valid", bus.out_valid, 1'b0);
        chk("fl_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fl_dropped", bus.out_valid, 1'b0);

        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b11, 6'h0D, 6'h0, 5'h0, 6'h09, 6'h0, 5'h0);
        @(posedge clk);
        #1;
        chk("ar_one", bus.out_valid, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", bus.out_valid, 1'b0);
        chk("ar_ready", bus.in_ready, 1'b1);
        chk("ar_funct", bus.out_funct, 14'h0);
        chk("ar_mask", bus.out_lane_mask, 2'b00);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int l = 0; l < IW; l++) begin
                rop[6*l +: 6] = ops[$urandom_range(0, 22)];
                rfn[6*l +: 6] = 6'($urandom);
                rrt[5*l +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(16, 17))
                                                            : 5'($urandom);
            end
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.out_ready    = ($urandom_range(0, 3) != 0);
            bus.flush        = ($urandom_range(0, 31) == 0);
            bus.in_lane_mask = 2'($urandom);
            bus.in_op        = rop;
            bus.in_funct     = rfn;
            bus.in_rt        = rrt;
            #1;
            chk("rnd_valid", bus.out_valid, q.size() > 0);
            chk("rnd_ready", bus.in_ready, q.size() < 2);
            if (q.size() > 0) begin
                chk("rnd_funct", bus.out_funct, q[0].f);
                chk("rnd_ill", bus.out_illegal, q[0].ill);
                chk("rnd_mask", bus.out_lane_mask, q[0].mask);
            end
            e   = ref_bundle(bus.in_lane_mask, rop, rfn, rrt);
            acc = bus.in_valid && (q.size() < 2) && !bus.flush;
            rdm = (q.size() > 0) && bus.out_ready;
            @(posedge clk);
            if (rdm) void'(q.pop_front());
            if (bus.flush) q.delete();
            else if (acc) q.push_back(e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
